// File: rtl/td4_ctl_pkg.sv
// Shared encodings for the TD4 run/debug controller: commands, FSM states,
// halt causes and the stop-condition bundle.
package td4_ctl_pkg;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_LOAD      = 3'd1;
  localparam logic [2:0] CMD_RUN       = 3'd2;
  localparam logic [2:0] CMD_STEP      = 3'd3;
  localparam logic [2:0] CMD_HALT      = 3'd4;
  localparam logic [2:0] CMD_SETBP     = 3'd5;
  localparam logic [2:0] CMD_CLRBP     = 3'd6;
  localparam logic [2:0] CMD_RESET_CPU = 3'd7;

  localparam logic [2:0] ST_CORE_RST = 3'd0;
  localparam logic [2:0] ST_HALT     = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_STEP     = 3'd4;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_BP       = 2'd1;
  localparam logic [1:0] CAUSE_SELFLOOP = 2'd2;
  localparam logic [1:0] CAUSE_LIMIT    = 2'd3;

  localparam logic [3:0] OP_JMP = 4'hF;

  typedef struct packed {
    logic bp;
    logic sl;
    logic lim;
  } stop_t;

  // Highest-priority active stop wins: breakpoint, then self-loop, then limit.
  function automatic logic [1:0] stop_cause(input stop_t s);
    if (s.bp)       return CAUSE_BP;
    else if (s.sl)  return CAUSE_SELFLOOP;
    else if (s.lim) return CAUSE_LIMIT;
    else            return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/td4_loader.sv
// Program-memory loader: accepts bytes from the host stream and writes them
// sequentially from address 0 up to the latched last address.
module td4_loader
  import td4_ctl_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned INSN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_last,
  input  logic              i_ld_valid,
  input  logic [INSN_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  output logic              o_done_c,
  output logic              o_pm_we,
  output logic [ADDR_W-1:0] o_pm_waddr,
  output logic [INSN_W-1:0] o_pm_wdata
);

  logic              r_active;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_pm_waddr;
  logic [INSN_W-1:0] r_pm_wdata;
  logic              w_hs;

  assign w_hs       = r_active && i_ld_valid;
  assign o_done_c   = w_hs && (r_waddr == r_last);
  assign o_ld_ready = r_active;
  assign o_pm_we    = r_we;
  assign o_pm_waddr = r_pm_waddr;
  assign o_pm_wdata = r_pm_wdata;

  // Write port trails each handshake by one cycle; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_active   <= 1'b0;
      r_waddr    <= '0;
      r_last     <= '0;
      r_we       <= 1'b0;
      r_pm_waddr <= '0;
      r_pm_wdata <= '0;
    end else begin
      r_we <= w_hs;
      if (w_hs) begin
        r_pm_waddr <= r_waddr;
        r_pm_wdata <= i_ld_data;
        r_waddr    <= r_waddr + ADDR_W'(1);
      end
      if (i_start) begin
        r_active <= 1'b1;
        r_last   <= i_last;
        r_waddr  <= '0;
      end else if (o_done_c) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/td4_runctl.sv
// Run/debug controller for the TD4 core: sequences program load, core reset,
// free-run/step execution and the breakpoint, self-loop and cycle-limit stops.
module td4_runctl
  import td4_ctl_pkg::*;
#(
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned INSN_W        = 8,
  parameter int unsigned SELFLOOP_HALT = 1,
  parameter int unsigned RUN_LIMIT     = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd,
  input  logic [ADDR_W-1:0] cmd_arg,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [INSN_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] pc,
  input  logic [INSN_W-1:0] instr,
  output logic              cpu_en,
  output logic              core_rst_n,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_waddr,
  output logic [INSN_W-1:0] pm_wdata,
  output logic [2:0]        state,
  output logic [1:0]        halt_cause,
  output logic              cmd_err
);

  logic [2:0]        r_state,     w_state_nxt;
  logic [1:0]        r_cause,     w_cause_nxt;
  logic              r_bp_en,     w_bp_en_nxt;
  logic [ADDR_W-1:0] r_bp_addr,   w_bp_addr_nxt;
  logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
  logic              r_skip,      w_skip_nxt;
  logic              r_cmd_err,   w_cmd_err_nxt;
  logic              w_ld_start;
  logic              w_ld_done;
  logic              w_cmd_hs;
  stop_t             w_stop;
  logic              w_stop_any;

  td4_loader #(
    .ADDR_W (ADDR_W),
    .INSN_W (INSN_W)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_ld_start),
    .i_last     (cmd_arg),
    .i_ld_valid (ld_valid),
    .i_ld_data  (ld_data),
    .o_ld_ready (ld_ready),
    .o_done_c   (w_ld_done),
    .o_pm_we    (pm_we),
    .o_pm_waddr (pm_waddr),
    .o_pm_wdata (pm_wdata)
  );

  // Stop conditions are evaluated on the instruction about to execute.
  assign w_stop.bp  = r_bp_en && (pc == r_bp_addr) && !r_skip;
  assign w_stop.sl  = (SELFLOOP_HALT != 0) && (instr[INSN_W-1 -: 4] == OP_JMP)
                      && (instr[ADDR_W-1:0] == pc);
  assign w_stop.lim = (RUN_LIMIT != 0) && (r_cnt == CNT_W'(RUN_LIMIT));
  assign w_stop_any = w_stop.bp || w_stop.sl || w_stop.lim;

  assign cmd_ready  = (r_state == ST_HALT) || (r_state == ST_RUN);
  assign w_cmd_hs   = cmd_valid && cmd_ready;
  assign cpu_en     = ((r_state == ST_RUN) && !w_stop_any) || (r_state == ST_STEP);
  assign core_rst_n = reset && (r_state != ST_CORE_RST);
  assign state      = r_state;
  assign halt_cause = r_cause;
  assign cmd_err    = r_cmd_err;

  // Next-state and datapath-register updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_cause_nxt   = r_cause;
    w_bp_en_nxt   = r_bp_en;
    w_bp_addr_nxt = r_bp_addr;
    w_cnt_nxt     = r_cnt;
    w_skip_nxt    = r_skip;
    w_cmd_err_nxt = 1'b0;
    w_ld_start    = 1'b0;

    case (r_state)
      ST_CORE_RST: w_state_nxt = ST_HALT;

      ST_HALT: begin
        if (w_cmd_hs) begin
          case (cmd)
            CMD_LOAD: begin
              w_ld_start  = 1'b1;
              w_state_nxt = ST_LOAD;
            end
            CMD_RUN: begin
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = '0;
              w_cause_nxt = CAUSE_NONE;
              w_skip_nxt  = 1'b1;
            end
            CMD_STEP: begin
              w_state_nxt = ST_STEP;
              w_cause_nxt = CAUSE_NONE;
            end
            CMD_SETBP: begin
              w_bp_addr_nxt = cmd_arg;
              w_bp_en_nxt   = 1'b1;
            end
            CMD_CLRBP: w_bp_en_nxt = 1'b0;
            CMD_RESET_CPU: begin
              w_state_nxt = ST_CORE_RST;
              w_cause_nxt = CAUSE_NONE;
            end
            default: begin
            end
          endcase
        end
      end

      ST_LOAD: begin
        if (w_ld_done) w_state_nxt = ST_CORE_RST;
      end

      ST_RUN: begin
        if (cpu_en) begin
          w_skip_nxt = 1'b0;
          if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (w_stop_any) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = stop_cause(w_stop);
        end
        // A host HALT leaves any same-cycle stop cause in place.
        if (w_cmd_hs) begin
          case (cmd)
            CMD_NOP: begin
            end
            CMD_HALT:      w_state_nxt   = ST_HALT;
            CMD_RESET_CPU: w_state_nxt   = ST_CORE_RST;
            default:       w_cmd_err_nxt = 1'b1;
          endcase
        end
      end

      ST_STEP: w_state_nxt = ST_HALT;

      default: w_state_nxt = ST_CORE_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_CORE_RST;
      r_cause   <= CAUSE_NONE;
      r_bp_en   <= 1'b0;
      r_bp_addr <= '0;
      r_cnt     <= '0;
      r_skip    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cause   <= w_cause_nxt;
      r_bp_en   <= w_bp_en_nxt;
      r_bp_addr <= w_bp_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_skip    <= w_skip_nxt;
      r_cmd_err <= w_cmd_err_nxt;
    end
  end

endmodule

// File: tb/tb_td4_runctl.sv
// Bench for td4_runctl with a behavioural TD4 fetch/JMP model and a
// program-write scoreboard.
module tb_td4_runctl;
  import td4_ctl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd = 3'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [7:0] ld_data = 8'd0;
  logic [3:0] pc = 4'd0;
  logic [7:0] instr;
  logic       cpu_en, core_rst_n, pm_we;
  logic [3:0] pm_waddr;
  logic [7:0] pm_wdata;
  logic [2:0] state;
  logic [1:0] halt_cause;
  logic       cmd_err;

  always #5 clk = ~clk;

  td4_runctl #(
    .ADDR_W(4), .INSN_W(8), .SELFLOOP_HALT(1), .RUN_LIMIT(5), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_arg(cmd_arg), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .pc(pc), .instr(instr), .cpu_en(cpu_en),
    .core_rst_n(core_rst_n), .pm_we(pm_we), .pm_waddr(pm_waddr),
    .pm_wdata(pm_wdata), .state(state), .halt_cause(halt_cause), .cmd_err(cmd_err)
  );

  // Minimal core: JMP im when op==F, otherwise pc+1.
  logic [7:0] mem [16];
  assign instr = mem[pc];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (pm_we) begin
      mem[pm_waddr] <= pm_wdata;
    end
    if (!core_rst_n) pc <= 4'd0;
    else if (cpu_en) pc <= (mem[pc][7:4] == 4'hF) ? mem[pc][3:0] : pc + 4'd1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int exp_waddr = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         due;
  } wr_t;
  wr_t wq[$];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts enables/errors, and checks every pm write against the queue.
  always @(negedge clk) begin
    wr_t w;
    if (cpu_en) en_cnt++;
    if (cmd_err) err_cnt++;
    if (pm_we) begin
      if (wq.size() == 0) begin
        chk("pm_we_unexpected", int'(pm_waddr), -1);
      end else begin
        w = wq.pop_front();
        chk("pm_waddr", int'(pm_waddr), int'(w.addr));
        chk("pm_wdata", int'(pm_wdata), int'(w.data));
        chk("pm_latency_cycle", cyc, w.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [3:0] a);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd = c;
    cmd_arg = a;
    tick();
    cmd_valid = 1'b0;
    cmd = CMD_NOP;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    wr_t w;
    chk("ld_ready", int'(ld_ready), 1);
    w.addr = 4'(exp_waddr);
    w.data = d;
    w.due  = cyc + 1;
    wq.push_back(w);
    exp_waddr++;
    ld_valid = 1'b1;
    ld_data = d;
    tick();
    ld_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (state != ST_HALT && n < 60) begin
      tick();
      n++;
    end
    if (state != ST_HALT) chk("halt_timeout", int'(state), int'(ST_HALT));
  endtask

  typedef struct {
    logic [2:0] c;
    logic [3:0] a;
    logic [1:0] cause;
    logic [3:0] pc;
    int         en;
    int         err;
  } vec_t;
  vec_t tbl[11];

  initial begin
    // Program 31,50,F2 is loaded first; each row starts from HALT.
    tbl[0]  = '{CMD_RUN,       4'd0, CAUSE_SELFLOOP, 4'd2, 2, 0};
    tbl[1]  = '{CMD_SETBP,     4'd1, CAUSE_SELFLOOP, 4'd2, 0, 0};
    tbl[2]  = '{CMD_RESET_CPU, 4'd0, CAUSE_NONE,     4'd0, 0, 0};
    tbl[3]  = '{CMD_RUN,       4'd0, CAUSE_BP,       4'd1, 1, 0};
    tbl[4]  = '{CMD_RUN,       4'd0, CAUSE_SELFLOOP, 4'd2, 1, 0};
    tbl[5]  = '{CMD_RESET_CPU, 4'd0, CAUSE_NONE,     4'd0, 0, 0};
    tbl[6]  = '{CMD_CLRBP,     4'd0, CAUSE_NONE,     4'd0, 0, 0};
    tbl[7]  = '{CMD_STEP,      4'd0, CAUSE_NONE,     4'd1, 1, 0};
    tbl[8]  = '{CMD_STEP,      4'd0, CAUSE_NONE,     4'd2, 1, 0};
    tbl[9]  = '{CMD_STEP,      4'd0, CAUSE_NONE,     4'd2, 1, 0};
    tbl[10] = '{CMD_HALT,      4'd0, CAUSE_NONE,     4'd2, 0, 0};

    // Reset held three cycles, then one CORE_RST cycle.
    repeat (3) begin
      tick();
      chk("rst_core_rst_n", int'(core_rst_n), 0);
    end
    reset = 1'b1;
    #1;
    chk("rst_state_core_rst", int'(state), int'(ST_CORE_RST));
    chk("rst_core_rst_n_extra", int'(core_rst_n), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    tick();
    chk("rst_state_halt", int'(state), int'(ST_HALT));
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_cmd_ready_halt", int'(cmd_ready), 1);
    chk("rst_halt_cause", int'(halt_cause), 0);
    chk("rst_core_rst_n_rel", int'(core_rst_n), 1);
    chk("rst_pm_we", int'(pm_we), 0);

    // Load three bytes with gaps; expect one core-reset cycle afterwards.
    send_cmd(CMD_LOAD, 4'd2);
    chk("load_state", int'(state), int'(ST_LOAD));
    chk("load_cmd_ready", int'(cmd_ready), 0);
    exp_waddr = 0;
    send_byte(8'h31, 2);
    send_byte(8'h50, 1);
    send_byte(8'hF2, 0);
    chk("load_done_core_rst", int'(state), int'(ST_CORE_RST));
    chk("load_done_core_rst_n", int'(core_rst_n), 0);
    tick();
    chk("load_then_halt", int'(state), int'(ST_HALT));
    chk("load_then_pc0", int'(pc), 0);

    for (int i = 0; i < 11; i++) begin
      en_cnt = 0;
      err_cnt = 0;
      send_cmd(tbl[i].c, tbl[i].a);
      wait_halt();
      tick();
      chk($sformatf("v%0d_state", i), int'(state), int'(ST_HALT));
      chk($sformatf("v%0d_cause", i), int'(halt_cause), int'(tbl[i].cause));
      chk($sformatf("v%0d_pc", i), int'(pc), int'(tbl[i].pc));
      chk($sformatf("v%0d_en_cycles", i), en_cnt, tbl[i].en);
      chk($sformatf("v%0d_cmd_err", i), err_cnt, tbl[i].err);
    end

    // JMP-0 loop, bad commands during RUN, limit stop after five cycles.
    send_cmd(CMD_LOAD, 4'd1);
    exp_waddr = 0;
    send_byte(8'h31, 1);
    send_byte(8'hF0, 0);
    tick();
    chk("loop_load_halt", int'(state), int'(ST_HALT));
    en_cnt = 0;
    err_cnt = 0;
    send_cmd(CMD_RUN, 4'd0);
    send_cmd(CMD_SETBP, 4'd0);
    chk("run_setbp_state", int'(state), int'(ST_RUN));
    send_cmd(CMD_LOAD, 4'd3);
    chk("run_load_state", int'(state), int'(ST_RUN));
    wait_halt();
    tick();
    chk("lim_en_cycles", en_cnt, 5);
    chk("lim_cmd_err", err_cnt, 2);
    chk("lim_cause", int'(halt_cause), int'(CAUSE_LIMIT));
    chk("lim_pc", int'(pc), 1);

    // Host HALT right after RUN: accept cycle still executes one instruction.
    en_cnt = 0;
    err_cnt = 0;
    send_cmd(CMD_RUN, 4'd0);
    send_cmd(CMD_HALT, 4'd0);
    chk("hcmd_state", int'(state), int'(ST_HALT));
    chk("hcmd_cause", int'(halt_cause), int'(CAUSE_NONE));
    tick();
    chk("hcmd_en_cycles", en_cnt, 1);
    chk("hcmd_pc", int'(pc), 0);
    chk("hcmd_cmd_err", err_cnt, 0);

    // Reset mid-load: the handshake at the reset edge must not write.
    send_cmd(CMD_LOAD, 4'd3);
    exp_waddr = 0;
    send_byte(8'h12, 1);
    ld_valid = 1'b1;
    ld_data = 8'h34;
    reset = 1'b0;
    tick();
    chk("ldrst_state", int'(state), int'(ST_CORE_RST));
    chk("ldrst_ld_ready", int'(ld_ready), 0);
    chk("ldrst_core_rst_n", int'(core_rst_n), 0);
    reset = 1'b1;
    ld_valid = 1'b0;
    tick();
    chk("ldrst_halt", int'(state), int'(ST_HALT));
    repeat (3) tick();
    chk("ldrst_no_pm_we", int'(pm_we), 0);
    chk("wq_drained", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
